// File: rtl/mem_helper_pkg.sv
// Shared types and helpers for the multi-port simulation memory helper.
package mem_helper_pkg;

    localparam int WORD_W = 64;
    localparam int IDX_W  = 64;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // One beat travelling down a read delay line.
    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_beat_t;

    function automatic word_t mask_merge(input word_t old_word, input word_t data, input word_t mask);
        return (data & mask) | (old_word & ~mask);
    endfunction

    function automatic logic in_range(input idx_t idx, input idx_t depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Per-port read delay line: a sample register followed by LATENCY stages of {valid, data}.
// Data in each stage only moves when a valid beat arrives, so the output holds its last read.
module mem_read_pipe
    import mem_helper_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  in_valid,
    input  word_t in_data,
    output logic  out_valid,
    output word_t out_data
);

    rd_beat_t [LATENCY:0] stage_d;
    rd_beat_t [LATENCY:0] stage_q;

    // NOTE: start from the held value so every path assigns stage_d and no latch is inferred.
    always_comb begin
        stage_d          = stage_q;
        stage_d[0].valid = in_valid;
        if (in_valid) begin
            stage_d[0].data = in_data;
        end
        for (int k = 1; k <= LATENCY; k++) begin
            stage_d[k].valid = stage_q[k-1].valid;
            if (stage_q[k-1].valid) begin
                stage_d[k].data = stage_q[k-1].data;
            end
        end
    end

    // NOTE: non-blocking assignment so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid = stage_q[LATENCY].valid;
    assign out_data  = stage_q[LATENCY].data;

endmodule

// File: rtl/mem_nrmw_helper.sv
// NR-read / NW-write 64-bit word store with ordered masked writes, optional same-cycle
// read bypass, fixed-latency read strobes and a sticky out-of-range flag.
module mem_nrmw_helper
    import mem_helper_pkg::*;
#(
    parameter logic [63:0] RAM_SIZE     = 64'h8000_0000,
    parameter int          NR           = 2,
    parameter int          NW           = 1,
    parameter int          READ_LATENCY = 1,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NR-1:0]        r_enable,
    input  logic [NR*IDX_W-1:0]  r_index,
    output logic [NR*WORD_W-1:0] r_data,
    output logic [NR-1:0]        r_valid,
    output logic                 r_async,
    input  logic [NW-1:0]        w_enable,
    input  logic [NW*IDX_W-1:0]  w_index,
    input  logic [NW*WORD_W-1:0] w_data,
    input  logic [NW*WORD_W-1:0] w_mask,
    output logic                 oob_error
);

    localparam idx_t DEPTH = idx_t'(RAM_SIZE >> 3);
    localparam int   AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    idx_t          r_idx   [NR];
    logic [AW-1:0] r_addr  [NR];
    logic [NR-1:0] r_ok;
    logic [NR-1:0] r_oob;
    word_t         rd_word [NR];

    idx_t          w_idx   [NW];
    word_t         w_dat   [NW];
    word_t         w_msk   [NW];
    logic [AW-1:0] w_addr  [NW];
    logic [NW-1:0] w_ok;
    logic [NW-1:0] w_oob;
    word_t         w_word  [NW];

    logic          oob_error_d;
    logic          oob_error_q;

    word_t         mem_q   [0:DEPTH-1];

    always_comb begin
        r_ok  = '0;
        r_oob = '0;
        for (int p = 0; p < NR; p++) begin
            r_idx[p]  = r_index[p*IDX_W +: IDX_W];
            r_addr[p] = r_idx[p][AW-1:0];
            r_ok[p]   = r_enable[p] && in_range(r_idx[p], DEPTH);
            r_oob[p]  = r_enable[p] && !in_range(r_idx[p], DEPTH);
        end
    end

    always_comb begin
        w_ok  = '0;
        w_oob = '0;
        for (int q = 0; q < NW; q++) begin
            w_idx[q]  = w_index[q*IDX_W +: IDX_W];
            w_dat[q]  = w_data[q*WORD_W +: WORD_W];
            w_msk[q]  = w_mask[q*WORD_W +: WORD_W];
            w_addr[q] = w_idx[q][AW-1:0];
            w_ok[q]   = w_enable[q] && in_range(w_idx[q], DEPTH);
            w_oob[q]  = w_enable[q] && !in_range(w_idx[q], DEPTH);
        end
    end

    // Each write port computes the final word for its index by folding in every port
    // that targets the same index, lowest port first, so colliding ports agree.
    always_comb begin
        for (int q = 0; q < NW; q++) begin
            w_word[q] = mem_q[w_addr[q]];
            for (int k = 0; k < NW; k++) begin
                if (w_ok[k] && (w_idx[k] == w_idx[q])) begin
                    w_word[q] = mask_merge(w_word[q], w_dat[k], w_msk[k]);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NR; p++) begin
            rd_word[p] = '0;
            if (r_ok[p]) begin
                rd_word[p] = mem_q[r_addr[p]];
                if (BYPASS) begin
                    for (int q = 0; q < NW; q++) begin
                        if (w_ok[q] && (w_idx[q] == r_idx[p])) begin
                            rd_word[p] = w_word[q];
                        end
                    end
                end
            end
        end
    end

    // NOTE: the backing store is deliberately not reset; contents come from the image preload.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int q = 0; q < NW; q++) begin
                if (w_ok[q]) begin
                    mem_q[w_addr[q]] <= w_word[q];
                end
            end
        end
    end

    always_comb begin
        oob_error_d = oob_error_q;
        if ((|r_oob) || (|w_oob)) begin
            oob_error_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oob_error_q <= 1'b0;
        end else begin
            oob_error_q <= oob_error_d;
        end
    end

    for (genvar p = 0; p < NR; p++) begin : g_rd
        mem_read_pipe #(
            .LATENCY (READ_LATENCY)
        ) u_pipe (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (r_enable[p]),
            .in_data   (rd_word[p]),
            .out_valid (r_valid[p]),
            .out_data  (r_data[p*WORD_W +: WORD_W])
        );
    end

    assign r_async   = 1'b0;
    assign oob_error = oob_error_q;

endmodule

// File: tb/tb_mem_nrmw_helper.sv
// Scoreboard bench: two helper instances (bypass/latency 1 and no-bypass/latency 3) share one
// randomized stimulus stream and are checked against a sequential word-array reference model.
module tb_mem_nrmw_helper;

    localparam int          NR      = 2;
    localparam int          NW      = 2;
    localparam int          DEPTH   = 64;
    localparam logic [63:0] DEPTH64 = 64'(DEPTH);
    localparam logic [63:0] RAMSZ   = 64'(DEPTH * 8);
    localparam int          LAT_A   = 1;
    localparam int          LAT_B   = 3;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic [NR-1:0]     r_enable  = '0;
    logic [NR*64-1:0]  r_index   = '0;
    logic [NW-1:0]     w_enable  = '0;
    logic [NW*64-1:0]  w_index   = '0;
    logic [NW*64-1:0]  w_data    = '0;
    logic [NW*64-1:0]  w_mask    = '0;
    logic [NR*64-1:0]  r_data_a;
    logic [NR*64-1:0]  r_data_b;
    logic [NR-1:0]     r_valid_a;
    logic [NR-1:0]     r_valid_b;
    logic              r_async_a;
    logic              r_async_b;
    logic              oob_a;
    logic              oob_b;

    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    exp_t        exp_q     [2][NR][$];
    logic [63:0] last_data [2][NR];
    logic [63:0] mdl       [DEPTH];
    bit          oob_exp   = 1'b0;
    int          lat       [2] = '{LAT_A, LAT_B};
    bit          byp       [2] = '{1'b1, 1'b0};

    logic [NR-1:0] s_re = '0;
    logic [63:0]   s_ri [NR];
    logic [NW-1:0] s_we = '0;
    logic [63:0]   s_wi [NW];
    logic [63:0]   s_wd [NW];
    logic [63:0]   s_wm [NW];

    mem_nrmw_helper #(
        .RAM_SIZE (RAMSZ), .NR (NR), .NW (NW), .READ_LATENCY (LAT_A), .BYPASS (1'b1)
    ) dut_a (
        .clock (clock), .reset (reset),
        .r_enable (r_enable), .r_index (r_index), .r_data (r_data_a), .r_valid (r_valid_a),
        .r_async (r_async_a),
        .w_enable (w_enable), .w_index (w_index), .w_data (w_data), .w_mask (w_mask),
        .oob_error (oob_a)
    );

    mem_nrmw_helper #(
        .RAM_SIZE (RAMSZ), .NR (NR), .NW (NW), .READ_LATENCY (LAT_B), .BYPASS (1'b0)
    ) dut_b (
        .clock (clock), .reset (reset),
        .r_enable (r_enable), .r_index (r_index), .r_data (r_data_b), .r_valid (r_valid_b),
        .r_async (r_async_b),
        .w_enable (w_enable), .w_index (w_index), .w_data (w_data), .w_mask (w_mask),
        .oob_error (oob_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Monitor: pops the expected beat whenever a read strobe appears; otherwise data must hold.
    always @(negedge clock) begin : monitor
        logic        v;
        logic [63:0] dat;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NR; p++) begin
                v   = (d == 0) ? r_valid_a[p] : r_valid_b[p];
                dat = (d == 0) ? r_data_a[p*64 +: 64] : r_data_b[p*64 +: 64];
                if (v) begin
                    if (exp_q[d][p].size() == 0) begin
                        check($sformatf("unexpected_valid_dut%0d_p%0d", d, p), 64'd1, 64'd0);
                    end else begin
                        e = exp_q[d][p].pop_front();
                        check($sformatf("rdata_dut%0d_p%0d", d, p), dat, e.data);
                        check($sformatf("latency_dut%0d_p%0d", d, p), 64'(edge_n), 64'(e.due));
                        last_data[d][p] = e.data;
                    end
                end else begin
                    check($sformatf("hold_dut%0d_p%0d", d, p), dat, last_data[d][p]);
                end
            end
        end
    end

    // Drives the staged request and advances the reference model by one accepted edge.
    task automatic apply();
        logic [63:0] pre [NR];
        logic [63:0] post;
        exp_t        e;
        for (int p = 0; p < NR; p++) begin
            r_enable[p]         = s_re[p];
            r_index[p*64 +: 64] = s_ri[p];
            pre[p]              = 64'h0;
            if (s_ri[p] < DEPTH64) pre[p] = mdl[int'(s_ri[p])];
        end
        for (int q = 0; q < NW; q++) begin
            w_enable[q]         = s_we[q];
            w_index[q*64 +: 64] = s_wi[q];
            w_data[q*64 +: 64]  = s_wd[q];
            w_mask[q*64 +: 64]  = s_wm[q];
        end
        if (!reset) begin
            for (int q = 0; q < NW; q++) begin
                if (s_we[q]) begin
                    if (s_wi[q] < DEPTH64) begin
                        mdl[int'(s_wi[q])] = (s_wd[q] & s_wm[q]) | (mdl[int'(s_wi[q])] & ~s_wm[q]);
                    end else begin
                        oob_exp = 1'b1;
                    end
                end
            end
            for (int p = 0; p < NR; p++) begin
                if (s_re[p]) begin
                    post = 64'h0;
                    if (s_ri[p] < DEPTH64) post = mdl[int'(s_ri[p])];
                    else oob_exp = 1'b1;
                    for (int d = 0; d < 2; d++) begin
                        e.data = byp[d] ? post : pre[p];
                        e.due  = edge_n + 1 + lat[d];
                        exp_q[d][p].push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        s_re = '0;
        s_we = '0;
        apply();
        repeat (n) tick();
    endtask

    function automatic logic [63:0] rnd_idx(input int span, input bit allow_oob);
        if (allow_oob && ($urandom_range(0, 7) == 0)) begin
            if ($urandom_range(0, 1) == 1) return {32'h1, 32'($urandom)};
            return DEPTH64 + 64'($urandom_range(0, 3));
        end
        return 64'($urandom_range(0, span - 1));
    endfunction

    task automatic random_phase(input int cycles, input bit allow_oob);
        int span;
        for (int c = 0; c < cycles; c++) begin
            span = ($urandom_range(0, 1) == 1) ? 16 : DEPTH;
            for (int p = 0; p < NR; p++) begin
                s_re[p] = ($urandom_range(0, 2) != 0);
                s_ri[p] = rnd_idx(span, allow_oob);
            end
            for (int q = 0; q < NW; q++) begin
                s_we[q] = 1'($urandom_range(0, 1));
                s_wi[q] = rnd_idx(span, allow_oob);
                s_wd[q] = {32'($urandom), 32'($urandom)};
                s_wm[q] = ($urandom_range(0, 3) == 0) ? '1 : {32'($urandom), 32'($urandom)};
            end
            apply();
            tick();
        end
    endtask

    task automatic check_pending(input string tag);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NR; p++)
                check($sformatf("%s_pending_dut%0d_p%0d", tag, d, p), 64'(exp_q[d][p].size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rvalid_a"}, 64'(r_valid_a), 64'd0);
        check({tag, "_rvalid_b"}, 64'(r_valid_b), 64'd0);
        check({tag, "_rdata_a"}, r_data_a[63:0] | r_data_a[127:64], 64'd0);
        check({tag, "_rdata_b"}, r_data_b[63:0] | r_data_b[127:64], 64'd0);
        check({tag, "_oob_a"}, 64'(oob_a), 64'(oob_exp));
        check({tag, "_oob_b"}, 64'(oob_b), 64'(oob_exp));
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NR; p++)
                last_data[d][p] = '0;
        for (int p = 0; p < NR; p++) s_ri[p] = '0;
        for (int q = 0; q < NW; q++) begin
            s_wi[q] = '0;
            s_wd[q] = '0;
            s_wm[q] = '0;
        end
        #1 reset = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        check("r_async_a", 64'(r_async_a), 64'd0);
        check("r_async_b", 64'(r_async_b), 64'd0);
        reset = 1'b0;

        // Image preload: every word written once with a full mask, two ports per cycle.
        for (int i = 0; i < DEPTH; i += 2) begin
            s_re = '0;
            s_we = '1;
            for (int q = 0; q < NW; q++) begin
                s_wi[q] = 64'(i + q);
                s_wd[q] = {32'($urandom), 32'($urandom)};
                s_wm[q] = '1;
            end
            apply();
            tick();
        end
        idle(1);

        // Full-mask write then read of index 5 on the following cycle.
        s_we = 2'b01; s_wi[0] = 64'd5; s_wd[0] = 64'hDEAD_BEEF_0000_1111; s_wm[0] = '1;
        apply(); tick();
        s_we = '0; s_re = 2'b01; s_ri[0] = 64'd5;
        apply(); tick();
        idle(LAT_B + 2);

        // Back-to-back reads on both ports.
        for (int i = 1; i <= 3; i++) begin
            s_re = 2'b11; s_ri[0] = 64'(i); s_ri[1] = 64'(4 - i);
            apply(); tick();
        end
        idle(LAT_B + 2);

        // Two-port collision on index 7 with a same-cycle read, then a plain read.
        s_we = 2'b01; s_wi[0] = 64'd7; s_wd[0] = 64'h0123_4567_89AB_CDEF; s_wm[0] = '1;
        apply(); tick();
        s_we = 2'b11;
        s_wi[0] = 64'd7; s_wd[0] = '1;    s_wm[0] = 64'hFFFF_FFFF_0000_0000;
        s_wi[1] = 64'd7; s_wd[1] = 64'h0; s_wm[1] = 64'h0000_FFFF_FFFF_0000;
        s_re = 2'b10; s_ri[1] = 64'd7;
        apply(); tick();
        s_we = '0; s_re = 2'b01; s_ri[0] = 64'd7;
        apply(); tick();
        idle(LAT_B + 2);

        // Same-cycle write/read of index 9: bypass instance sees new data, the other old.
        s_we = 2'b01; s_wi[0] = 64'd9; s_wd[0] = {16{4'h5}}; s_wm[0] = '1;
        apply(); tick();
        s_we = 2'b01; s_wd[0] = {16{4'hA}};
        s_re = 2'b01; s_ri[0] = 64'd9;
        apply(); tick();
        idle(LAT_B + 2);

        random_phase(400, 1'b0);
        idle(LAT_B + 2);
        check_pending("inrange");
        check("oob_clear_a", 64'(oob_a), 64'(oob_exp));
        check("oob_clear_b", 64'(oob_b), 64'(oob_exp));

        // First out-of-range access: read at exactly the depth.
        s_re = 2'b01; s_ri[0] = DEPTH64;
        apply(); tick();
        idle(LAT_B + 4);
        check("oob_set_a", 64'(oob_a), 64'(oob_exp));
        check("oob_set_b", 64'(oob_b), 64'(oob_exp));

        random_phase(150, 1'b1);
        idle(LAT_B + 2);
        check_pending("oob");
        check("oob_sticky_a", 64'(oob_a), 64'(oob_exp));
        check("oob_sticky_b", 64'(oob_b), 64'(oob_exp));

        // Reset one cycle after a request: in-flight reads vanish, writes under reset are dropped.
        s_we = '0; s_re = 2'b11; s_ri[0] = 64'd5; s_ri[1] = 64'd9;
        apply(); tick();
        reset = 1'b1;
        oob_exp = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NR; p++) begin
                exp_q[d][p].delete();
                last_data[d][p] = '0;
            end
        for (int c = 0; c < 3; c++) begin
            s_re = 2'b11; s_we = 2'b11;
            for (int q = 0; q < NW; q++) begin
                s_wi[q] = 64'($urandom_range(0, 15));
                s_wd[q] = {32'($urandom), 32'($urandom)};
                s_wm[q] = '1;
            end
            apply(); tick();
        end
        idle(1);
        check_quiet("midreset");
        reset = 1'b0;
        for (int i = 0; i < 16; i += 2) begin
            s_re = 2'b11; s_ri[0] = 64'(i); s_ri[1] = 64'(i + 1);
            apply(); tick();
        end
        idle(LAT_B + 2);
        check_pending("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
